hazard_unit_mc: RTL

- Parametrised next-generation hazard/forwarding controller for the 5-stage pipeline (F/D/E/M/W).
- Adds three things to classic forward/stall/flush:
  - a multi-cycle multiply/divide (HI/LO) busy tracker, as an FSM plus counter;
  - a variable-latency data-memory stall handshake that freezes the whole pipe;
  - register-zero-safe load-use and branch checks.
- Sits beside the datapath; all stage-enable and flush signals come from here.

---
 rtl/hazard_unit_mc_if.sv | 37 +++
 rtl/hazard_unit_mc.sv | 137 +++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: datapath register numbers and stage flags in, stage controls out.
// The slave modport is the hazard unit side; the master modport is the datapath side.
interface hazard_unit_mc_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) ();
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
    logic [REG_AW-1:0] writeregE, writeregM, writeregW;
    logic              regwriteE, regwriteM, regwriteW;
    logic              memtoregE, memtoregM;
    logic              branchD, mdstartE, mdreqD;
    logic              dmem_reqM, dmem_readyM;
    logic              stallF, stallD, stallE, stallM;
    logic              flushE, flushW;
    logic              forwardAD, forwardBD;
    logic [1:0]        forwardAE, forwardBE;
    logic              md_busy, md_done;
    logic [CNT_W-1:0]  stall_cycles;

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        input  branchD, mdstartE, mdreqD, dmem_reqM, dmem_readyM,
        output stallF, stallD, stallE, stallM, flushE, flushW,
        output forwardAD, forwardBD, forwardAE, forwardBE,
        output md_busy, md_done, stall_cycles
    );

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        output branchD, mdstartE, mdreqD, dmem_reqM, dmem_readyM,
        input  stallF, stallD, stallE, stallM, flushE, flushW,
        input  forwardAD, forwardBD, forwardAE, forwardBE,
        input  md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// 5-stage pipeline hazard/forwarding controller with HI/LO busy tracking and memory-wait freeze.
// Define HAZARD_PERF_EN to build the saturating stall_cycles performance counter.
module hazard_unit_mc #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 32
) (
    input logic             clk,
    input logic             reset,
    hazard_unit_mc_if.slave hz
);
    localparam logic [REG_AW-1:0] Zero   = '0;
    localparam logic [7:0]        MdLoad = 8'(MD_LATENCY - 1);

    typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

    md_state_e  state_q, state_d;
    logic [7:0] mdcnt_q, mdcnt_d;
    logic       md_done;

    logic rs_d_hit_e, rt_d_hit_e, rs_d_hit_m, rt_d_hit_m;
    logic lwstall, brstall, mdstall, memstall;
    logic stall_f, stall_d, stall_e, stall_m, flush_e, flush_w;

    assign rs_d_hit_e = (hz.rsD != Zero) && (hz.rsD == hz.writeregE);
    assign rt_d_hit_e = (hz.rtD != Zero) && (hz.rtD == hz.writeregE);
    assign rs_d_hit_m = (hz.rsD != Zero) && (hz.rsD == hz.writeregM);
    assign rt_d_hit_m = (hz.rtD != Zero) && (hz.rtD == hz.writeregM);

    assign lwstall  = hz.memtoregE && (rs_d_hit_e || rt_d_hit_e);
    assign brstall  = hz.branchD && ((hz.regwriteE && (rs_d_hit_e || rt_d_hit_e)) ||
                                     (hz.memtoregM && (rs_d_hit_m || rt_d_hit_m)));
    assign mdstall  = hz.mdreqD && (state_q == StBusy);
    assign memstall = hz.dmem_reqM && !hz.dmem_readyM;

    assign hz.forwardAD = rs_d_hit_m && hz.regwriteM;
    assign hz.forwardBD = rt_d_hit_m && hz.regwriteM;

    always_comb begin
        hz.forwardAE = 2'b00;
        if (hz.rsE != Zero && hz.rsE == hz.writeregM && hz.regwriteM) begin
            hz.forwardAE = 2'b10;
        end else if (hz.rsE != Zero && hz.rsE == hz.writeregW && hz.regwriteW) begin
            hz.forwardAE = 2'b01;
        end
    end

    always_comb begin
        hz.forwardBE = 2'b00;
        if (hz.rtE != Zero && hz.rtE == hz.writeregM && hz.regwriteM) begin
            hz.forwardBE = 2'b10;
        end else if (hz.rtE != Zero && hz.rtE == hz.writeregW && hz.regwriteW) begin
            hz.forwardBE = 2'b01;
        end
    end

    // A memory wait freezes every stage and outranks the D-stage bubble.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (memstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (lwstall || brstall || mdstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.stallF = stall_f;
    assign hz.stallD = stall_d;
    assign hz.stallE = stall_e;
    assign hz.stallM = stall_m;
    assign hz.flushE = flush_e;
    assign hz.flushW = flush_w;

    // The HI/LO unit keeps counting through memory waits; only acceptance waits for E to move.
    always_comb begin
        state_d = state_q;
        mdcnt_d = mdcnt_q;
        md_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hz.mdstartE && !memstall) begin
                    state_d = StBusy;
                    mdcnt_d = MdLoad;
                end
            end
            StBusy: begin
                if (mdcnt_q == 8'd0) begin
                    md_done = 1'b1;
                    state_d = StIdle;
                end else begin
                    mdcnt_d = mdcnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            mdcnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            mdcnt_q <= mdcnt_d;
        end
    end

    assign hz.md_busy = (state_q == StBusy);
    assign hz.md_done = md_done;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = stall_cnt_q;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule
